// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the EX-stage DIV/DIVU path.
// EX holds start_i high until ready_o rises; the block captures the operands,
// runs 32 trial subtractions and returns {remainder, quotient} for HI/LO.
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous reset, active low
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU), sampled with start
//   opdata1_i     dividend, sampled with start
//   opdata2_i     divisor, sampled with start
//   start_i       level request, held until ready_o is seen
//   annul_i       abort current/pending division (flush)
//   result_o      {remainder[31:0], quotient[31:0]}, registered
//   ready_o       result valid, registered
//
// state   | meaning
// S_FREE  | idle, waiting for start_i
// S_BYZERO| divisor was zero, result forced to 0
// S_ON    | iterating trial subtractions (cnt 0..32)
// S_END   | result presented, waiting for start_i to drop
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [64:0] r_dividend;
  logic [31:0] r_divisor;
  logic [5:0]  r_cnt;
  logic        r_op1_neg;
  logic        r_op2_neg;

  logic        w_op1_neg;
  logic        w_op2_neg;
  logic [31:0] w_op1_mag;
  logic [31:0] w_op2_mag;
  logic [32:0] w_trial;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_accept;

  // Signedness is folded into the neg flags; 0x8000_0000 negates to itself
  // and is then simply used as an unsigned magnitude.
  assign w_op1_neg = signed_div_i & opdata1_i[31];
  assign w_op2_neg = signed_div_i & opdata2_i[31];
  assign w_op1_mag = w_op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_op2_mag = w_op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;

  assign w_accept  = start_i & ~annul_i;

  assign w_trial   = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

  // Remainder follows the sign of the dividend.
  assign w_quot = (r_op1_neg ^ r_op2_neg) ? (~r_dividend[31:0] + 32'd1) : r_dividend[31:0];
  assign w_rem  = r_op1_neg ? (~r_dividend[64:33] + 32'd1) : r_dividend[64:33];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FREE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FREE: begin
        if (w_accept) w_next = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
      end
      S_BYZERO: w_next = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i)               w_next = S_FREE;
        else if (r_cnt == 6'd32)   w_next = S_END;
      end
      S_END: begin
        if (annul_i || !start_i) w_next = S_FREE;
      end
      default: w_next = S_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_cnt      <= '0;
      r_op1_neg  <= 1'b0;
      r_op2_neg  <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (w_accept && (opdata2_i != 32'd0)) begin
            r_op1_neg  <= w_op1_neg;
            r_op2_neg  <= w_op2_neg;
            r_dividend <= {32'd0, w_op1_mag, 1'b0};
            r_divisor  <= w_op2_mag;
            r_cnt      <= '0;
          end
        end
        S_BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b0;
        end
        S_ON: begin
          if (annul_i) begin
            r_cnt    <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (r_cnt == 6'd32) begin
            r_cnt    <= '0;
            result_o <= {w_rem, w_quot};
            ready_o  <= 1'b1;
          end else begin
            if (w_trial[32]) r_dividend <= {r_dividend[63:0], 1'b0};
            else             r_dividend <= {w_trial[31:0], r_dividend[31:0], 1'b1};
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_END: begin
          // Divide-by-zero enters END with ready low; it rises here.
          if (annul_i || !start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            ready_o  <= 1'b1;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed/unsigned arithmetic on 64-bit integers.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, ma, mb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q  = ma / mb;
    r  = ma % mb;
    if ((sa < 0) != (sb < 0)) q = -q;
    if (sa < 0) r = -r;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Full transaction: issue, check exact latency, hold, drop start, check clear.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input int hold, input string tag);
    int lat;
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    step();                              // E0
    opdata1_i    = $urandom;             // must be ignored from here on
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    lat = (b == 32'd0) ? 2 : 33;
    for (int i = 1; i < lat; i++) begin
      step();
      check({tag, "_busy"}, {63'd0, ready_o}, 64'd0);
    end
    step();
    check({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
    check({tag, "_result"}, result_o, exp);
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, "_hold_rdy"}, {63'd0, ready_o}, 64'd1);
      check({tag, "_hold_res"}, result_o, exp);
    end
    start_i = 1'b0;
    step();
    check({tag, "_drop_rdy"}, {63'd0, ready_o}, 64'd0);
    check({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    logic        seen;

    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    #1;
    check("reset_rdy", {63'd0, ready_o}, 64'd0);
    check("reset_res", result_o, 64'd0);
    #11 rst = 1'b1;
    step();

    do_div(32'd100, 32'd7, 1'b0, 64'h0000_0002_0000_000E, 0, "u100_7");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1, "sm7_2");
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 0, "s7_m2");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 0, "s_ovf");
    do_div(32'd5, 32'd0, 1'b0, 64'd0, 1, "div0");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, {32'h1, 32'h7FFF_FFFC}, 0, "u_big");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0}, 0, "u_ovf");

    // Annul at iteration 10, then a fresh division with exact latency.
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    step();
    repeat (10) step();
    annul_i = 1'b1; start_i = 1'b0;
    step();
    check("annul_on_rdy", {63'd0, ready_o}, 64'd0);
    check("annul_on_res", result_o, 64'd0);
    annul_i = 1'b0;
    do_div(32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 0, "after_annul");

    // Annul in END clears the presented result.
    opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
    step();
    repeat (33) step();
    check("end_rdy", {63'd0, ready_o}, 64'd1);
    check("end_res", result_o, {32'h0, 32'd10});
    annul_i = 1'b1;
    step();
    check("annul_end_rdy", {63'd0, ready_o}, 64'd0);
    check("annul_end_res", result_o, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    step();

    // Start together with annul in FREE must not launch anything.
    opdata1_i = 32'd10; opdata2_i = 32'd2; start_i = 1'b1; annul_i = 1'b1;
    step();
    start_i = 1'b0; annul_i = 1'b0;
    seen = 1'b0;
    repeat (36) begin
      step();
      seen = seen | ready_o;
    end
    check("start_annul_free", {63'd0, seen}, 64'd0);

    // Async reset while result is presented.
    opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    step();
    repeat (33) step();
    check("pre_rst_res", result_o, {32'd1, 32'd333});
    #2 rst = 1'b0;
    #1;
    check("async_rst_end_rdy", {63'd0, ready_o}, 64'd0);
    check("async_rst_end_res", result_o, 64'd0);
    start_i = 1'b0;
    step();
    #3 rst = 1'b1;
    step();

    // Async reset mid-ON (iteration 20), then 1 / 1.
    opdata1_i = 32'd77; opdata2_i = 32'd7; start_i = 1'b1;
    step();
    repeat (20) step();
    #2 rst = 1'b0;
    #1;
    check("async_rst_on_rdy", {63'd0, ready_o}, 64'd0);
    check("async_rst_on_res", result_o, 64'd0);
    start_i = 1'b0;
    #3 rst = 1'b1;
    step();
    do_div(32'd1, 32'd1, 1'b0, {32'h0, 32'h1}, 0, "post_rst");

    // Randomised operands against the arithmetic reference.
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = $urandom;
        2:       b = 32'd0 - 32'($urandom_range(1, 9));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      s = 1'($urandom_range(0, 1));
      do_div(a, b, s, ref_div(a, b, s), $urandom_range(0, 2), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle radix-2 restoring divider and its sequencing FSM, serving the EX stage's DIV/DIVU path. EX drives operands, signedness and a level `start_i` request and holds the pipeline stalled until `ready_o` rises. The block captures the operands and iterates 32 trial subtractions. It then returns `{remainder, quotient}` for writing to HI/LO. It supports annulment (flush) mid-operation and returns a defined divide-by-zero result.

## Interface
- No parameters; data width fixed at 32 bits, result 64 bits.
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- `opdata1_i`  in  32  dividend; sampled with start.
- `opdata2_i`  in  32  divisor; sampled with start.
- `start_i`  in  1  level request; EX holds it high until it sees `ready_o`.
- `annul_i`  in  1  abort current/pending division (pipeline flush).
- `result_o`  out  64  `{remainder[31:0], quotient[31:0]}`, registered.
- `ready_o`  out  1  result valid, registered.

## Operation
- The FSM has four states: FREE, BYZERO, ON, END.
- Datapath registers:
  - `dividend[64:0]`, `divisor[31:0]`, `cnt[5:0]`, plus captured `sgn`, `op1_neg` and `op2_neg` flags.
- FREE:
  - If `start_i=1` and `annul_i=0`:
    - If `opdata2_i==0`, go to BYZERO.
    - Otherwise capture `sgn=signed_div_i`, `op1_neg=sgn&opdata1_i[31]` and `op2_neg=sgn&opdata2_i[31]`.
    - Magnitudes are two's-complement negated when the corresponding neg flag is set; `0x8000_0000` maps to itself and is treated as unsigned.
    - Load `dividend={32'b0, |op1|, 1'b0}`, `divisor=|op2|`, `cnt=0`, and go to ON.
  - Otherwise stay in FREE.
- BYZERO: next state is END, with `result_o=64'h0`.
- ON, when `annul_i=1`: go to FREE, clear `cnt`, and force `result_o=0`, `ready_o=0`.
- ON, otherwise, while `cnt<32`, each cycle:
  - Compute `t={1'b0,dividend[63:32]}-{1'b0,divisor}` (33 bits).
  - If `t[32]=1`, `dividend<={dividend[63:0],1'b0}`.
  - Else `dividend<={t[31:0],dividend[31:0],1'b1}`.
  - Increment `cnt`.
- ON, at `cnt==32`:
  - `quotient=dividend[31:0]`, negated if `op1_neg^op2_neg`.
  - `remainder=dividend[64:33]`, negated if `op1_neg`; the remainder takes the sign of the dividend.
  - Load `result_o={remainder,quotient}`, set `ready_o=1`, go to END.
- END:
  - While `start_i=1`, hold `result_o` and `ready_o=1`.
  - When `start_i=0` is sampled, go to FREE with `ready_o=0` and `result_o=0`.
  - `annul_i` in END also returns to FREE and clears outputs.
- `annul_i` in BYZERO goes to FREE.
- Operand inputs are ignored outside the FREE capture edge; changes during ON have no effect.
- Signed overflow `0x8000_0000 / 0xFFFF_FFFF` produces quotient `0x8000_0000` and remainder 0 (wraps, no trap).

## Timing
- Reset (async, `rst=0`) forces state=FREE, `cnt=0`, `dividend=0`, `divisor=0`, `result_o=64'h0` and `ready_o=0` immediately, with no clock required. Release is synchronous to the next rising edge.
- Latency, with edge E0 being the edge that samples `start_i=1` in FREE:
  - Normal division: `ready_o` rises after E0+33 (1 capture + 32 iterations, sign fix-up folded into the 33rd edge). EX therefore stalls 34 cycles including the issue cycle.
  - Divide by zero: `ready_o` rises after E0+2.
- `ready_o` stays high for at least one cycle, and exactly one cycle when EX drops `start_i` in the cycle it sees `ready_o`.
- A new start sampled in the same edge that leaves END is not accepted; earliest re-acceptance is the following edge from FREE.
- Simultaneous `start_i` and `annul_i` in FREE: annul wins and no operation starts.
- Throughput: one division in flight; no queuing.

## Test plan
- Unsigned 100 / 7, `signed_div_i=0`, start held: `ready_o` rises 33 edges after start; `result_o=64'h0000_0002_0000_000E`; drop start, then `ready_o=0` and `result_o=0` next edge.
- Signed -7 / 2 (`0xFFFF_FFF9`, `0x2`): `result_o={0xFFFF_FFFF, 0xFFFF_FFFD}`.
- Signed 7 / -2: quotient `0xFFFF_FFFD`, remainder `0x1`.
- Signed overflow `0x8000_0000 / 0xFFFF_FFFF`: `result_o={0x0, 0x8000_0000}`, ready at E0+33.
- Divide by zero, 5 / 0: `ready_o` rises after E0+2 with `result_o=0`.
- `annul_i` pulsed at iteration 10: next edge state is FREE and `ready_o=0`. A fresh start of 9 / 3 then returns `{0x0, 0x3}` at its own E0+33.
- Async reset asserted mid-ON (iteration 20, between clock edges): `ready_o` and `result_o` go to 0 immediately. After release, a 1 / 1 division returns `{0x0, 0x1}`.
